// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, width helper and default-width types for the
// streaming 3x3 convolution engine.
package conv_pkg;
    localparam int TAPS       = 9;
    localparam int WIDX_BIAS  = 9;
    localparam int DATA_W_DEF = 16;

    function automatic int acc_width(input int data_w);
        return 2 * data_w + 4;
    endfunction

    typedef logic signed [DATA_W_DEF-1:0]   pix_t;
    typedef logic signed [2*DATA_W_DEF+3:0] acc_t;
endpackage

// File: rtl/conv3x3_mac.sv
// conv3x3_mac: one output channel -- 9 signed products, then adder tree plus bias.
// Defining CONV3X3_RELU_EN clamps negative results to zero without extra latency.
module conv3x3_mac
    import conv_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = acc_width(DATA_W)
) (
    input  logic                        clk,
    input  logic                        RESET_N,
    input  logic                        en_mul,
    input  logic                        en_sum,
    input  logic [TAPS-1:0][DATA_W-1:0] pix,
    input  logic [TAPS-1:0][DATA_W-1:0] wts,
    input  logic [DATA_W-1:0]           bias,
    output logic signed [ACC_W-1:0]     res
);
    logic signed [2*DATA_W-1:0] prod [TAPS];
    logic signed [DATA_W-1:0]   bias_q;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    tree;

    always_comb begin
        tree = ACC_W'(bias_q);
        for (int j = 0; j < TAPS; j++) tree = tree + ACC_W'(prod[j]);
    end

    always_ff @(posedge clk or negedge RESET_N)
        if (!RESET_N) begin
            prod   <= '{default: '0};
            bias_q <= '0;
            sum    <= '0;
        end else begin
            if (en_mul) begin
                for (int j = 0; j < TAPS; j++)
                    prod[j] <= (2*DATA_W)'($signed(pix[j])) * (2*DATA_W)'($signed(wts[j]));
                bias_q <= bias;
            end
            if (en_sum) sum <= tree;
        end

`ifdef CONV3X3_RELU_EN
    assign res = sum[ACC_W-1] ? '0 : sum;
`else
    assign res = sum;
`endif
endmodule

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 valid convolution, N_OUT channels, circular line buffers,
// double-buffered weights. Define CONV3X3_RELU_EN to clamp negative results to zero.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int N_OUT  = 3,
    parameter int ACC_W  = acc_width(DATA_W),
    localparam int NWT   = N_OUT * (TAPS + 1),
    localparam int AW    = $clog2(NWT)
) (
    input  logic                     clk,
    input  logic                     RESET_N,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     w_we,
    input  logic [AW-1:0]            w_addr,
    input  logic [DATA_W-1:0]        w_data,
    input  logic                     w_commit,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [N_OUT*ACC_W-1:0]   out_data,
    output logic                     busy,
    output logic                     err_sof
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col, pc;
    logic [RW-1:0] row, pr;
    logic accept, at_end, do_swap, pending;
    logic [NWT-1:0][DATA_W-1:0] shd, act, snap;
    logic [DATA_W-1:0] lb_a [IMG_W];
    logic [DATA_W-1:0] lb_b [IMG_W];
    logic [DATA_W-1:0] pix0, up1, up2;
    logic [TAPS-1:0][DATA_W-1:0] win;
    logic v0, ok0, last0, v1, last1, v2, last2;

    // Outside a frame only an in_sof pixel is accepted.
    always_comb begin
        accept  = in_valid && (busy || in_sof);
        pc      = in_sof ? '0 : col;
        pr      = in_sof ? '0 : row;
        at_end  = pc == CW'(IMG_W - 1) && pr == RW'(IMG_H - 1);
        do_swap = pending && (!busy || (in_valid && in_sof));
    end

    always_ff @(posedge clk or negedge RESET_N)
        if (!RESET_N) begin
            col     <= '0;
            row     <= '0;
            busy    <= 1'b0;
            err_sof <= 1'b0;
            pending <= 1'b0;
            shd     <= '0;
            act     <= '0;
            v0      <= 1'b0;
            ok0     <= 1'b0;
            last0   <= 1'b0;
        end else begin
            v0 <= accept;
            if (accept) begin
                col   <= (pc == CW'(IMG_W - 1)) ? '0 : pc + 1'b1;
                row   <= (pc != CW'(IMG_W - 1)) ? pr : at_end ? '0 : pr + 1'b1;
                busy  <= !at_end;
                ok0   <= pr >= RW'(2) && pc >= CW'(2);
                last0 <= at_end;
                if (in_sof && busy) err_sof <= 1'b1;
            end
            if (w_we && w_addr < AW'(NWT)) shd[w_addr] <= w_data;
            if (do_swap) act <= shd;
            pending <= !do_swap && (pending || w_commit);
        end

    // Read-before-write: lb_a holds the previous line, lb_b the one before it.
    always_ff @(posedge clk)
        if (accept) begin
            pix0     <= in_data;
            up1      <= lb_a[pc];
            up2      <= lb_b[pc];
            lb_a[pc] <= in_data;
            lb_b[pc] <= lb_a[pc];
        end

    // Weights are snapshotted with each valid window so a swap at the next frame's
    // first pixel cannot reach results of the previous frame still in flight.
    always_ff @(posedge clk or negedge RESET_N)
        if (!RESET_N) begin
            win       <= '0;
            snap      <= '0;
            v1        <= 1'b0;
            last1     <= 1'b0;
            v2        <= 1'b0;
            last2     <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            v1        <= v0 && ok0;
            last1     <= last0;
            v2        <= v1;
            last2     <= last1;
            out_valid <= v2;
            out_last  <= v2 && last2;
            if (v0) begin
                for (int r = 0; r < 3; r++) begin
                    win[r*3]   <= win[r*3+1];
                    win[r*3+1] <= win[r*3+2];
                end
                win[2] <= up2;
                win[5] <= up1;
                win[8] <= pix0;
                if (ok0) snap <= act;
            end
        end

    for (genvar k = 0; k < N_OUT; k++) begin : g_ch
        conv3x3_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
            .clk     (clk),
            .RESET_N (RESET_N),
            .en_mul  (v1),
            .en_sum  (v2),
            .pix     (win),
            .wts     (snap[k*(TAPS+1) +: TAPS]),
            .bias    (snap[k*(TAPS+1) + WIDX_BIAS]),
            .res     (out_data[k*ACC_W +: ACC_W])
        );
    end
endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
- Parametrised streaming 3x3 convolution engine; successor to the fixed 28-wide, 3-kernel, single-output convolution layer.
- Takes a raster pixel stream from the input interface and keeps the two previous lines in circular line buffers.
- Computes N_OUT independent signed 3x3 "valid" convolutions (no padding), each with its own bias.
- Drives the next layer (pooling/FC) with a packed per-channel result stream. Kernel weights are double-buffered and reloadable while a frame is in flight.

Parameters:
- DATA_W, 16, signed pixel and weight width
- IMG_W, 28, pixels per line (>=3)
- IMG_H, 28, lines per frame (>=3)
- N_OUT, 3, output channels (kernels)
- ACC_W, 2*DATA_W+4, signed accumulator/result width per channel

Ports:
- clk  in  1  system clock, all logic on rising edge
- RESET_N  in  1  asynchronous active-low reset
- in_valid  in  1  pixel strobe
- in_sof  in  1  first pixel of frame, qualified by in_valid
- in_data  in  DATA_W  signed pixel
- w_we  in  1  weight/bias write strobe to shadow bank
- w_addr  in  clog2(N_OUT*10)  index k*10+j; j=0..8 taps row-major, j=9 bias
- w_data  in  DATA_W  signed weight or bias
- w_commit  in  1  request shadow->active swap at next frame start
- out_valid  out  1  result strobe
- out_last  out  1  last result of frame
- out_data  out  N_OUT*ACC_W  channel k at bits [k*ACC_W +: ACC_W]
- busy  out  1  frame in progress
- err_sof  out  1  sticky: in_sof seen mid-frame

Behaviour:
- Clocking/reset: one clock, rising edge only. Reset is asynchronous and active-low on RESET_N. On reset, all outputs = 0; counters, pipeline valids and the commit flag clear; both weight banks clear to 0. Line-buffer RAM content is don't-care.
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1) advance only on in_valid.
  - in_sof with in_valid forces col=0, row=0 for that pixel.
  - col wraps IMG_W-1 -> 0 and increments row.
  - The pixel at row IMG_H-1, col IMG_W-1 ends the frame: busy drops the next cycle.
- Stalls: gaps in in_valid are legal. Nothing advances on idle cycles and no spurious outputs are produced.
- Line buffers: two IMG_W-deep RAMs, read-before-write at address col. The 3x3 window is shifted in on in_valid only.
- Window validity: the window is valid when row>=2 and col>=2. This gives (IMG_W-2)*(IMG_H-2) results per frame, in raster order.
- Pipeline latency: exactly 3 cycles from the accepting in_valid edge to out_valid.
  - Stage 1: window register.
  - Stage 2: 9*N_OUT signed products, each 2*DATA_W bits.
  - Stage 3: sign-extended adder tree plus sign-extended bias into ACC_W bits.
  - No saturation; ACC_W is guaranteed not to overflow.
- out_data holds its value when out_valid=0. out_last accompanies the result for row IMG_H-1, col IMG_W-1.
- Weights:
  - w_we writes the shadow bank at any time. w_addr >= N_OUT*10 is ignored.
  - w_commit sets a pending flag.
  - The swap shadow->active happens on the cycle that accepts an in_sof pixel, or immediately if busy=0. The flag then clears.
  - The active bank never changes mid-frame.
  - w_commit together with the swap event still completes the swap; the flag ends clear.
- err_sof: in_sof while busy=1 and not at frame end sets err_sof (cleared only by reset). The frame restarts from that pixel.
- Reset mid-frame: pipeline outputs are discarded. The next frame requires in_sof.

Optional Feature:
- Macro CONV3X3_RELU_EN.
- Defined: each channel result is clamped to 0 when negative, with no added latency.
- Undefined: raw signed sums are output.

Decomposition:
- Package conv_pkg: ACC_W derivation function, WIDX_BIAS=9, TAPS=9, and the signed pixel/accumulator typedefs.
- Sub-module conv3x3_mac: one channel (9 multipliers + adder tree + bias, 2 pipeline stages), instantiated N_OUT times.
- Line buffers are inferred inline.

Test Plan (IMG_W=5, IMG_H=4, N_OUT=2, DATA_W=16):
1. Identity kernel for ch0 (tap4=1, bias 0); ch1 all taps 1, bias -3. Frame pixel = row*5+col. -> 6 results; ch0 = 6,7,8,11,12,13. ch1 = 9*centre-3, i.e. 51,60,69,96,105,114. out_last on the 6th result; first out_valid 3 cycles after pixel (2,2).
2. Same frame with in_valid toggled 1-0-0-1 randomly. -> identical result sequence, no extra strobes.
3. Load new shadow weights and pulse w_commit mid-frame. -> current frame uses the old weights; the next frame uses the new ones.
4. Constant pixel -4, ch0 all taps 2, bias 0. -> ch0 = -72, or 0 with CONV3X3_RELU_EN.
5. RESET_N low at pixel 9, then a full frame. -> outputs 0 during reset, then a correct 6-result frame.
6. in_sof at pixel 12 of a frame. -> err_sof=1; the frame restarts and produces 6 results.
